// File: rtl/load_store_ctrl.sv
// Command-side controller for the load/store volume unit: alternates fill and
// drain phases over a valid/ready command port and cross-checks the unit's full flag.
`timescale 1ns/1ps
module load_store_ctrl #(
    parameter int N     = 5000,
    parameter int CBITS = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             cmd_ready_i,
    input  logic             sig_i,
    output logic             cmd_valid_o,
    output logic             cmd_inc_o,
    output logic [CBITS-1:0] shadow_o,
    output logic [1:0]       phase_o,
    output logic             mismatch_o
);

    // Handshake: a command transfers on a rising edge with cmd_valid_o=1 and
    // cmd_ready_i=1; once raised, cmd_valid_o/cmd_inc_o hold until that edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } phase_e;

    localparam logic [CBITS-1:0] FULL = CBITS'(N);
    localparam logic [CBITS-1:0] ONE  = CBITS'(1);

    phase_e           state_q, state_d;
    logic [CBITS-1:0] shadow_q, shadow_d;
    logic             exp_full_q, exp_full_d;
    logic             valid_q, valid_d;
    logic             inc_q, inc_d;
    logic             mismatch_q, mismatch_d;

    logic accept;
    logic at_full;
    logic at_empty;
    logic check_err;

    assign accept    = valid_q & cmd_ready_i;
    assign at_full   = (shadow_q == FULL);
    assign at_empty  = (shadow_q == '0);
    // exp_full_q mirrors the one-cycle lag of the unit's registered full flag.
    assign check_err = ((state_q == FILL) || (state_q == DRAIN)) && (sig_i != exp_full_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            exp_full_q <= 1'b0;
            valid_q    <= 1'b0;
            inc_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            exp_full_q <= exp_full_d;
            valid_q    <= valid_d;
            inc_q      <= inc_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q & ~accept;
        inc_d      = inc_q;
        mismatch_d = mismatch_q;
        exp_full_d = at_full;
        shadow_d   = shadow_q;
        if (accept) begin
            shadow_d = inc_q ? (shadow_q + ONE) : (shadow_q - ONE);
        end

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = FILL;
                    valid_d = 1'b1;
                    inc_d   = 1'b1;
                end
            end
            FILL: begin
                if (check_err) begin
                    state_d    = FAULT;
                    valid_d    = 1'b0;
                    mismatch_d = 1'b1;
                end else if (valid_q) begin
                    // A pending load is never withdrawn; only reissue while enabled.
                    if (accept) begin
                        valid_d = en_i && (shadow_d != FULL);
                    end
                end else if (!en_i || (at_full && exp_full_q && sig_i)) begin
                    state_d = DRAIN;
                    inc_d   = 1'b0;
                    valid_d = !at_empty;
                end else if (!at_full) begin
                    valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (check_err) begin
                    state_d    = FAULT;
                    valid_d    = 1'b0;
                    mismatch_d = 1'b1;
                end else if (valid_q) begin
                    if (accept) begin
                        valid_d = (shadow_d != '0);
                    end
                end else if (en_i) begin
                    state_d = FILL;
                    inc_d   = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                valid_d    = 1'b0;
                mismatch_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_valid_o = valid_q;
    assign cmd_inc_o   = inc_q;
    assign shadow_o    = shadow_q;
    assign phase_o     = state_q;
    assign mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl with a small volume-unit model driving sig and a
// scoreboard of expected shadow counts pushed on each observed accept.
`timescale 1ns/1ps
module tb_load_store_ctrl;
    localparam int N     = 4;
    localparam int CBITS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             en;
    logic             cmd_ready;
    logic             sig_force;
    logic             sig_val;
    logic             sig_m;
    logic             sig;
    logic             cmd_valid;
    logic             cmd_inc;
    logic             mismatch;
    logic [CBITS-1:0] shadow;
    logic [CBITS-1:0] vol;
    logic [1:0]       phase;

    int               checks = 0;
    int               errors = 0;
    int               model_cnt = 0;
    logic [CBITS-1:0] exp_q[$];

    load_store_ctrl #(.N(N), .CBITS(CBITS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .cmd_ready_i (cmd_ready),
        .sig_i       (sig),
        .cmd_valid_o (cmd_valid),
        .cmd_inc_o   (cmd_inc),
        .shadow_o    (shadow),
        .phase_o     (phase),
        .mismatch_o  (mismatch)
    );

    // Volume unit: its full flag is registered from the pre-update volume.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol   <= '0;
            sig_m <= 1'b0;
        end else begin
            sig_m <= (vol == CBITS'(N));
            if (cmd_valid && cmd_ready) vol <= cmd_inc ? vol + 3'd1 : vol - 3'd1;
        end
    end
    assign sig = sig_force ? sig_val : sig_m;

    task automatic tick();
        logic [CBITS-1:0] exp_v;
        if (rst_n && cmd_valid && cmd_ready) begin
            model_cnt = cmd_inc ? model_cnt + 1 : model_cnt - 1;
            exp_q.push_back(CBITS'(model_cnt));
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (shadow !== exp_v) begin
                errors++;
                $display("FAIL sb_shadow: got %0d expected %0d at %0t", shadow, exp_v, $time);
            end
        end
    endtask

    task automatic wait_phase(input logic [1:0] p, input int budget);
        int i = 0;
        while (phase !== p && i < budget) begin
            tick();
            i++;
        end
    endtask

    task automatic wait_shadow(input logic [CBITS-1:0] s, input int budget);
        int i = 0;
        while (shadow !== s && i < budget) begin
            tick();
            i++;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        en        = 1'b0;
        cmd_ready = 1'b0;
        sig_force = 1'b0;
        sig_val   = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; cmd_ready = 1'b0; sig_force = 1'b0; sig_val = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rst_phase: got %0d expected 0", phase); end
        checks++; if (shadow !== 3'd0) begin errors++; $display("FAIL rst_shadow: got %0d expected 0", shadow); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", cmd_valid); end
        checks++; if (cmd_inc !== 1'b0) begin errors++; $display("FAIL rst_inc: got %0b expected 0", cmd_inc); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rst_mismatch: got %0b expected 0", mismatch); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        apply_reset();
        en = 1'b1;
        cmd_ready = 1'b1;
        tick();
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL fd_fill_entry: got %0d expected 1", phase); end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL fd_first_valid: got %0b expected 1", cmd_valid); end
        checks++; if (cmd_inc !== 1'b1) begin errors++; $display("FAIL fd_first_inc: got %0b expected 1", cmd_inc); end
        checks++; if (shadow !== 3'd0) begin errors++; $display("FAIL fd_first_shadow: got %0d expected 0", shadow); end
        wait_phase(2'd2, 20);
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL fd_drain_entry: got %0d expected 2", phase); end
        checks++; if (shadow !== 3'd4) begin errors++; $display("FAIL fd_peak: got %0d expected 4", shadow); end
        checks++; if (cmd_inc !== 1'b0) begin errors++; $display("FAIL fd_drain_inc: got %0b expected 0", cmd_inc); end
        wait_phase(2'd1, 20);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL fd_refill: got %0d expected 1", phase); end
        checks++; if (shadow !== 3'd0) begin errors++; $display("FAIL fd_empty: got %0d expected 0", shadow); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL fd_mismatch: got %0b expected 0", mismatch); end
    endtask

    task automatic test_backpressure();
        logic pv, pi, pr;
        int   cyc = 0;
        apply_reset();
        en = 1'b1;
        cmd_ready = 1'b0;
        tick();
        while (phase === 2'd1 && cyc < 40) begin
            pv = cmd_valid;
            pi = cmd_inc;
            pr = cmd_ready;
            tick();
            if (pv && !pr) begin
                checks++;
                if (cmd_valid !== 1'b1 || cmd_inc !== pi) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%0b inc=%0b expected valid=1 inc=%0b", cmd_valid, cmd_inc, pi);
                end
            end
            cmd_ready = ~cmd_ready;
            cyc++;
        end
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL bp_drain_entry: got %0d expected 2", phase); end
        checks++; if (shadow !== 3'd4) begin errors++; $display("FAIL bp_peak: got %0d expected 4", shadow); end
    endtask

    task automatic test_en_drop();
        apply_reset();
        en = 1'b1;
        cmd_ready = 1'b1;
        tick();
        wait_shadow(3'd2, 10);
        checks++; if (shadow !== 3'd2 || cmd_valid !== 1'b1 || cmd_inc !== 1'b1) begin
            errors++; $display("FAIL ed_pending: got shadow=%0d valid=%0b inc=%0b expected 2 1 1", shadow, cmd_valid, cmd_inc);
        end
        en = 1'b0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cmd_valid !== 1'b1 || cmd_inc !== 1'b1 || shadow !== 3'd2 || phase !== 2'd1) begin
                errors++; $display("FAIL ed_hold: got valid=%0b inc=%0b shadow=%0d phase=%0d expected 1 1 2 1", cmd_valid, cmd_inc, shadow, phase);
            end
        end
        cmd_ready = 1'b1;
        tick();
        checks++; if (shadow !== 3'd3 || cmd_valid !== 1'b0 || phase !== 2'd1) begin
            errors++; $display("FAIL ed_accept: got shadow=%0d valid=%0b phase=%0d expected 3 0 1", shadow, cmd_valid, phase);
        end
        tick();
        checks++; if (phase !== 2'd2 || shadow !== 3'd3 || cmd_valid !== 1'b1 || cmd_inc !== 1'b0) begin
            errors++; $display("FAIL ed_drain: got phase=%0d shadow=%0d valid=%0b inc=%0b expected 2 3 1 0", phase, shadow, cmd_valid, cmd_inc);
        end
        wait_phase(2'd0, 20);
        checks++; if (phase !== 2'd0 || shadow !== 3'd0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL ed_idle: got phase=%0d shadow=%0d valid=%0b expected 0 0 0", phase, shadow, cmd_valid);
        end
    endtask

    task automatic test_sig_fault();
        int frozen;
        apply_reset();
        en = 1'b1;
        cmd_ready = 1'b1;
        tick();
        wait_shadow(3'd1, 10);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL sf_pre: got %0d expected 1", phase); end
        sig_force = 1'b1;
        sig_val   = 1'b1;
        tick();
        checks++; if (phase !== 2'd3 || mismatch !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL sf_fault: got phase=%0d mismatch=%0b valid=%0b expected 3 1 0", phase, mismatch, cmd_valid);
        end
        frozen = model_cnt;
        for (int i = 0; i < 6; i++) begin
            en = ~en;
            tick();
            checks++; if (phase !== 2'd3 || mismatch !== 1'b1 || cmd_valid !== 1'b0 || shadow !== CBITS'(frozen)) begin
                errors++; $display("FAIL sf_hold: got phase=%0d mismatch=%0b valid=%0b shadow=%0d expected 3 1 0 %0d", phase, mismatch, cmd_valid, shadow, frozen);
            end
        end
    endtask

    task automatic test_sig_stuck_low();
        apply_reset();
        sig_force = 1'b1;
        sig_val   = 1'b0;
        en = 1'b1;
        cmd_ready = 1'b1;
        tick();
        wait_shadow(3'd4, 10);
        checks++; if (shadow !== 3'd4 || phase !== 2'd1) begin
            errors++; $display("FAIL sl_full: got shadow=%0d phase=%0d expected 4 1", shadow, phase);
        end
        tick();
        checks++; if (phase !== 2'd1 || mismatch !== 1'b0) begin
            errors++; $display("FAIL sl_detect: got phase=%0d mismatch=%0b expected 1 0", phase, mismatch);
        end
        tick();
        checks++; if (phase !== 2'd3 || mismatch !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL sl_fault: got phase=%0d mismatch=%0b valid=%0b expected 3 1 0", phase, mismatch, cmd_valid);
        end
    endtask

    task automatic test_rst_mid_drain();
        apply_reset();
        en = 1'b1;
        cmd_ready = 1'b1;
        tick();
        wait_phase(2'd2, 20);
        wait_shadow(3'd3, 10);
        checks++; if (phase !== 2'd2 || shadow !== 3'd3) begin
            errors++; $display("FAIL rd_pre: got phase=%0d shadow=%0d expected 2 3", phase, shadow);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (phase !== 2'd0 || shadow !== 3'd0 || cmd_valid !== 1'b0 || cmd_inc !== 1'b0 || mismatch !== 1'b0) begin
            errors++; $display("FAIL rd_async: got phase=%0d shadow=%0d valid=%0b inc=%0b mismatch=%0b expected all 0", phase, shadow, cmd_valid, cmd_inc, mismatch);
        end
        exp_q.delete();
        model_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (phase !== 2'd1 || shadow !== 3'd0 || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL rd_restart: got phase=%0d shadow=%0d valid=%0b expected 1 0 1", phase, shadow, cmd_valid);
        end
        wait_shadow(3'd4, 10);
        checks++; if (shadow !== 3'd4 || mismatch !== 1'b0) begin
            errors++; $display("FAIL rd_refill: got shadow=%0d mismatch=%0b expected 4 0", shadow, mismatch);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_backpressure();
        test_en_drop();
        test_sig_fault();
        test_sig_stuck_low();
        test_rst_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
